// File: rtl/dest_drain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dest_drain_arbiter: round-robin drain of the D0/D1 destination FIFOs |
// | into one registered valid/ready stream. Revision: 1.0                |
// +----------------------------------------------------------------------+
module dest_drain_arbiter #(
    parameter int data_width = 6,
    parameter int dest_bit   = 4,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  empty_D0,
    input  logic                  empty_D1,
    input  logic [data_width-1:0] data_D0,
    input  logic [data_width-1:0] data_D1,
    input  logic                  out_ready,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    output logic                  src_out,
    output logic [cnt_width-1:0]  cnt_D0,
    output logic [cnt_width-1:0]  cnt_D1,
    output logic                  error_out,
    output logic                  idle_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  src_q, src_d;
    logic [cnt_width-1:0]  cnt0_q, cnt0_d;
    logic [cnt_width-1:0]  cnt1_q, cnt1_d;
    logic                  error_q, error_d;

    logic                  pick;
    logic                  pop_req;
    logic [data_width-1:0] word_in;

    // A tie goes to the FIFO not served last; a lone non-empty FIFO always wins.
    assign pick    = empty_D0 ? 1'b1 : (empty_D1 ? 1'b0 : ~last_grant_q);
    assign pop_req = (state_q == ST_IDLE) && active && (!empty_D0 || !empty_D1);
    assign word_in = grant_q ? data_D1 : data_D0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pop_req) state_d = ST_WAIT;
            ST_WAIT: state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pops are gated by reset so nothing leaves the FIFOs while held in reset.
    always_comb begin
        D0_pop    = reset && pop_req && !pick;
        D1_pop    = reset && pop_req && pick;
        data_out  = data_q;
        valid_out = valid_q;
        src_out   = src_q;
        cnt_D0    = cnt0_q;
        cnt_D1    = cnt1_q;
        error_out = error_q;
        idle_out  = (state_q == ST_IDLE) && empty_D0 && empty_D1;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        data_d       = data_q;
        valid_d      = valid_q;
        src_d        = src_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        error_d      = error_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_req) begin
                    last_grant_d = pick;
                    grant_d      = pick;
                end
            end
            ST_WAIT: begin
                data_d  = word_in;
                src_d   = grant_q;
                valid_d = 1'b1;
                // A misrouted word is still forwarded; only the sticky flag records it.
                if (word_in[dest_bit] != grant_q) error_d = 1'b1;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (src_q) cnt1_d = cnt1_q + cnt_width'(1);
                    else       cnt0_d = cnt0_q + cnt_width'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            src_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            error_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            src_q        <= src_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            error_q      <= error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dest_drain_arbiter.sv
`default_nettype none
// Testbench for dest_drain_arbiter: FIFO models feed the DUT, a scoreboard
// queue holds the expected {src, word} order and is checked on each acceptance.
module tb_dest_drain_arbiter;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          active = 1'b1;
    logic          empty_D0 = 1'b1;
    logic          empty_D1 = 1'b1;
    logic [DW-1:0] data_D0 = '0;
    logic [DW-1:0] data_D1 = '0;
    logic          out_ready = 1'b1;
    logic          D0_pop, D1_pop;
    logic [DW-1:0] data_out;
    logic          valid_out, src_out;
    logic [CW-1:0] cnt_D0, cnt_D1;
    logic          error_out, idle_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW:0]   exp_q[$];
    int            pop_times[$];

    dest_drain_arbiter #(.data_width(DW), .dest_bit(4), .cnt_width(CW)) dut (
        .clk(clk), .reset(reset), .active(active),
        .empty_D0(empty_D0), .empty_D1(empty_D1),
        .data_D0(data_D0), .data_D1(data_D1), .out_ready(out_ready),
        .D0_pop(D0_pop), .D1_pop(D1_pop), .data_out(data_out),
        .valid_out(valid_out), .src_out(src_out),
        .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
        .error_out(error_out), .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    // FIFO models: read data appears the cycle after a pop.
    always @(posedge clk) begin
        cyc++;
        if (D0_pop) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty_D0 cycle %0d", cyc);
            end else begin
                data_D0 <= q0.pop_front();
                pop_times.push_back(cyc);
            end
        end
        if (D1_pop) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty_D1 cycle %0d", cyc);
            end else begin
                data_D1 <= q1.pop_front();
                pop_times.push_back(cyc);
            end
        end
        empty_D0 <= (q0.size() == 0);
        empty_D1 <= (q1.size() == 0);
    end

    // Scoreboard: each word is compared once, in the cycle it is accepted.
    always @(negedge clk) begin
        if (reset && valid_out && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got src=%0d data=%b", src_out, data_out);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({src_out, data_out} !== e) begin
                    errors++;
                    $display("FAIL word_order got src=%0d data=%b expected src=%0d data=%b",
                             src_out, data_out, e[DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic load(input logic src, input logic [DW-1:0] w);
        if (src) q1.push_back(w);
        else     q0.push_back(w);
        exp_q.push_back({src, w});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && idle_out && !valid_out) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout pending=%0d required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!valid_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s_valid_timeout valid_out=%0d required 1", name, valid_out);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        pop_times.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({D0_pop, D1_pop, data_out, valid_out, src_out, cnt_D0, cnt_D1, error_out} !== '0
            || idle_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_values data=%b valid=%0d cnt0=%0d cnt1=%0d err=%0d idle=%0d required zeros idle=1",
                     data_out, valid_out, cnt_D0, cnt_D1, error_out, idle_out);
        end
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (D0_pop !== 1'b0 || D1_pop !== 1'b0 || valid_out !== 1'b0 || idle_out !== 1'b1) begin
                errors++;
                $display("FAIL idle_no_pop pop0=%0d pop1=%0d valid=%0d idle=%0d required 0 0 0 1",
                         D0_pop, D1_pop, valid_out, idle_out);
            end
        end
        checks++;
        if (pop_times.size() != 0) begin
            errors++;
            $display("FAIL idle_pop_count got %0d required 0", pop_times.size());
        end
    endtask

    task automatic test_d0_stream();
        @(posedge clk); #1;
        pop_times.delete();
        load(1'b0, 6'b000001);
        load(1'b0, 6'b000010);
        load(1'b0, 6'b000011);
        load(1'b0, 6'b000100);
        wait_drain("d0_stream");
        checks++;
        if (pop_times.size() != 4) begin
            errors++;
            $display("FAIL d0_pop_count got %0d required 4", pop_times.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (pop_times[i] - pop_times[i-1] != 3) begin
                    errors++;
                    $display("FAIL d0_pop_spacing got %0d required 3", pop_times[i] - pop_times[i-1]);
                end
            end
        end
        checks++;
        if (cnt_D0 !== 8'd4 || cnt_D1 !== 8'd0 || error_out !== 1'b0) begin
            errors++;
            $display("FAIL d0_counts cnt0=%0d cnt1=%0d err=%0d required 4 0 0", cnt_D0, cnt_D1, error_out);
        end
    endtask

    task automatic test_both();
        do_reset();
        load(1'b0, 6'b000001);
        load(1'b1, 6'b110001);
        load(1'b0, 6'b000010);
        load(1'b1, 6'b110010);
        wait_drain("both");
        checks++;
        if (cnt_D0 !== 8'd2 || cnt_D1 !== 8'd2) begin
            errors++;
            $display("FAIL both_counts cnt0=%0d cnt1=%0d required 2 2", cnt_D0, cnt_D1);
        end
    endtask

    task automatic test_backpressure();
        int p;
        do_reset();
        out_ready = 1'b0;
        load(1'b0, 6'b000001);
        load(1'b0, 6'b000010);
        wait_valid("bp");
        p = pop_times.size();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (data_out !== 6'b000001 || valid_out !== 1'b1 || src_out !== 1'b0 || cnt_D0 !== 8'd0) begin
                errors++;
                $display("FAIL bp_hold data=%b valid=%0d src=%0d cnt0=%0d required 000001 1 0 0",
                         data_out, valid_out, src_out, cnt_D0);
            end
            @(negedge clk);
        end
        checks++;
        if (pop_times.size() != p) begin
            errors++;
            $display("FAIL bp_no_pop got %0d pops required %0d", pop_times.size(), p);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt_D0 !== 8'd0) begin
            errors++;
            $display("FAIL bp_cnt_before_accept got %0d required 0", cnt_D0);
        end
        @(negedge clk);
        checks++;
        if (cnt_D0 !== 8'd1) begin
            errors++;
            $display("FAIL bp_cnt_after_accept got %0d required 1", cnt_D0);
        end
        wait_drain("bp");
        checks++;
        if (cnt_D0 !== 8'd2) begin
            errors++;
            $display("FAIL bp_final_cnt got %0d required 2", cnt_D0);
        end
    endtask

    task automatic test_error();
        checks++;
        if (error_out !== 1'b0) begin
            errors++;
            $display("FAIL err_before got %0d required 0", error_out);
        end
        @(posedge clk); #1;
        load(1'b1, 6'b000011);
        wait_valid("err");
        checks++;
        if (error_out !== 1'b1) begin
            errors++;
            $display("FAIL err_at_capture got %0d required 1", error_out);
        end
        wait_drain("err");
        checks++;
        if (cnt_D1 !== 8'd1 || error_out !== 1'b1) begin
            errors++;
            $display("FAIL err_delivery cnt1=%0d err=%0d required 1 1", cnt_D1, error_out);
        end
        @(posedge clk); #1;
        load(1'b0, 6'b000100);
        wait_drain("err_sticky");
        checks++;
        if (error_out !== 1'b1 || cnt_D0 !== 8'd3) begin
            errors++;
            $display("FAIL err_sticky err=%0d cnt0=%0d required 1 3", error_out, cnt_D0);
        end
    endtask

    task automatic test_reset_in_hold();
        int p;
        @(posedge clk); #1;
        out_ready = 1'b0;
        load(1'b0, 6'b000101);
        wait_valid("rst_hold");
        reset = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== '0 || cnt_D0 !== '0 || cnt_D1 !== '0
            || error_out !== 1'b0 || src_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%0d data=%b cnt0=%0d cnt1=%0d err=%0d required all 0",
                     valid_out, data_out, cnt_D0, cnt_D1, error_out);
        end
        exp_q.delete();
        p = pop_times.size();
        load(1'b0, 6'b000110);
        load(1'b1, 6'b110111);
        repeat (3) @(negedge clk);
        checks++;
        if (pop_times.size() != p) begin
            errors++;
            $display("FAIL pop_in_reset got %0d pops required %0d", pop_times.size(), p);
        end
        reset = 1'b1;
        out_ready = 1'b1;
        wait_drain("rst_resume");
        checks++;
        if (cnt_D0 !== 8'd1 || cnt_D1 !== 8'd1 || error_out !== 1'b0) begin
            errors++;
            $display("FAIL resume_counts cnt0=%0d cnt1=%0d err=%0d required 1 1 0", cnt_D0, cnt_D1, error_out);
        end
    endtask

    initial begin
        test_reset();
        test_d0_stream();
        test_both();
        test_backpressure();
        test_error();
        test_reset_in_hold();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
